// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Optional misaligned-redirect trap is enabled by defining FETCH_MISALIGN_TRAP_EN.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/response bus between the fetch unit (master)
// and the instruction memory (slave). One request may be outstanding.
interface fetch_if #(
  parameter int word_width = 32
);

  logic                  imem_req_valid;
  logic                  imem_req_ready;
  logic [word_width-1:0] imem_addr;
  logic                  imem_rsp_valid;
  logic [word_width-1:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );

endinterface

// File: rtl/fetch_pc_gen.sv
// Program-counter register and next-PC selection for the fetch unit.
// Redirect beats sequential advance. With FETCH_MISALIGN_TRAP_EN defined a
// misaligned target is reported and not loaded; otherwise the low two target
// bits are cleared so the PC is always word aligned.
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter int                    word_width = 32,
  parameter logic [word_width-1:0] RESET_PC   = word_width'(DEFAULT_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  redirect_i,
  input  logic                  advance_i,
  input  logic [word_width-1:0] target_i,
  output logic [word_width-1:0] pc_o,
  output logic [word_width-1:0] pc_plus4_o,
  output logic                  misaligned_o
);

  localparam logic [word_width-1:0] ALIGN_MASK = {{(word_width-2){1'b1}}, 2'b00};

  logic [word_width-1:0] pc_d;
  logic [word_width-1:0] pc_q;
  logic [word_width-1:0] target_eff;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign misaligned_o = |target_i[1:0];
  assign target_eff   = target_i;
`else
  assign misaligned_o = 1'b0;
  assign target_eff   = target_i & ALIGN_MASK;
`endif

  assign pc_plus4_o = pc_q + word_width'(4);
  assign pc_o       = pc_q;

  // Pick the next PC: an aligned redirect wins, otherwise step by one word.
  always_comb begin
    pc_d = pc_q;
    if (redirect_i) begin
      if (!misaligned_o) begin
        pc_d = target_eff;
      end
    end else if (advance_i) begin
      pc_d = pc_plus4_o;
    end
  end

  // PC register, restarts at the configured reset vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one instruction-memory request at a time,
// presents the returned instruction to decode and holds it under stall.
// A redirect from execute overrides everything; a response belonging to a
// request issued before the redirect is dropped via the kill flag.
// Define FETCH_MISALIGN_TRAP_EN to trap misaligned redirect targets.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    word_width = 32,
  parameter logic [word_width-1:0] RESET_PC   = word_width'(DEFAULT_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  StallF,
  input  logic                  PCSrcE,
  input  logic [word_width-1:0] PCTargetE,
  fetch_if.master               imem,
  output logic [word_width-1:0] instrF,
  output logic [word_width-1:0] PCF,
  output logic [word_width-1:0] PCPlus4F,
  output logic                  validF,
  output logic                  misalign_o
);

  localparam logic [word_width-1:0] NOP_W = word_width'(NOP_INSTR);

  fetch_state_e          state_q, state_d;
  logic                  kill_q, kill_d;
  logic                  valid_q, valid_d;
  logic [word_width-1:0] instr_q, instr_d;
  logic [word_width-1:0] pcf_q, pcf_d;
  logic [word_width-1:0] pcplus4_q, pcplus4_d;

  logic [word_width-1:0] pc;
  logic [word_width-1:0] pc_plus4;
  logic                  pc_misaligned;
  logic                  redirect;
  logic                  consume;
  logic                  handshake;
  logic                  fault_take;

  // A trapped unit ignores further redirects until reset.
  assign redirect   = PCSrcE && (state_q != ST_FAULT);
  assign consume    = (state_q == ST_HOLD) && !StallF && !PCSrcE;
  assign fault_take = redirect && pc_misaligned;

  assign imem.imem_req_valid = rst_n && (state_q == ST_REQ);
  assign imem.imem_addr      = pc;
  assign handshake           = imem.imem_req_valid && imem.imem_req_ready;

  assign instrF   = instr_q;
  assign PCF      = pcf_q;
  assign PCPlus4F = pcplus4_q;
  assign validF   = valid_q;

  fetch_pc_gen #(
    .word_width (word_width),
    .RESET_PC   (RESET_PC)
  ) u_pc_gen (
    .clk          (clk),
    .rst_n        (rst_n),
    .redirect_i   (redirect),
    .advance_i    (consume),
    .target_i     (PCTargetE),
    .pc_o         (pc),
    .pc_plus4_o   (pc_plus4),
    .misaligned_o (pc_misaligned)
  );

  // Next-state and decode-register update for the fetch handshake FSM.
  always_comb begin
    state_d   = state_q;
    kill_d    = kill_q;
    valid_d   = valid_q;
    instr_d   = instr_q;
    pcf_d     = pcf_q;
    pcplus4_d = pcplus4_q;

    case (state_q)
      ST_REQ: begin
        if (redirect) begin
          // The request just accepted carries the old PC, so its data must die.
          state_d = handshake ? ST_WAIT : ST_REQ;
          kill_d  = handshake;
        end else if (handshake) begin
          state_d = ST_WAIT;
          kill_d  = 1'b0;
        end
      end
      ST_WAIT: begin
        if (redirect) begin
          if (imem.imem_rsp_valid) begin
            state_d = ST_REQ;
            kill_d  = 1'b0;
          end else begin
            kill_d  = 1'b1;
          end
        end else if (imem.imem_rsp_valid) begin
          if (kill_q) begin
            state_d = ST_REQ;
            kill_d  = 1'b0;
          end else begin
            state_d   = ST_HOLD;
            valid_d   = 1'b1;
            instr_d   = imem.imem_rsp_data;
            pcf_d     = pc;
            pcplus4_d = pc_plus4;
          end
        end
      end
      ST_HOLD: begin
        if (redirect || !StallF) begin
          state_d = ST_REQ;
          valid_d = 1'b0;
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_REQ;
      end
    endcase

    if (fault_take) begin
      state_d = ST_FAULT;
      valid_d = 1'b0;
      kill_d  = 1'b0;
    end

    if (!valid_d) begin
      instr_d = NOP_W;
    end
  end

  // State and decode-facing output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_REQ;
      kill_q    <= 1'b0;
      valid_q   <= 1'b0;
      instr_q   <= NOP_W;
      pcf_q     <= RESET_PC;
      pcplus4_q <= RESET_PC + word_width'(4);
    end else begin
      state_q   <= state_d;
      kill_q    <= kill_d;
      valid_q   <= valid_d;
      instr_q   <= instr_d;
      pcf_q     <= pcf_d;
      pcplus4_q <= pcplus4_d;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;

  assign misalign_d = misalign_q || fault_take;
  assign misalign_o = misalign_q;

  // Sticky misaligned-redirect flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end
`else
  assign misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by a
// randomized phase, all checked against a PC-stream reference model
// (expected PC advances by 4 per consumed instruction, jumps on redirect).
module tb_fetch_unit;

  localparam logic [31:0] RESET_VAL = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        StallF;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] instrF;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
  logic        validF;
  logic        misalign_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_pc = RESET_VAL;
  bit          model_fault = 1'b0;
  int          deliveries = 0;

  bit          mem_random = 1'b0;
  int          mem_lat = 1;
  bit          mem_pending = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr_q = '0;

  fetch_if #(.word_width(32)) imem ();

  fetch_unit #(
    .word_width (32),
    .RESET_PC   (RESET_VAL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .StallF     (StallF),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .imem       (imem),
    .instrF     (instrF),
    .PCF        (PCF),
    .PCPlus4F   (PCPlus4F),
    .validF     (validF),
    .misalign_o (misalign_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h1357_0000;
  endfunction

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit stall, input bit redir, input logic [31:0] tgt);
    StallF    = stall;
    PCSrcE    = redir;
    PCTargetE = tgt;
  endtask

  // Invariants that hold every cycle given the reference PC stream.
  task automatic checkOutput();
    if (validF === 1'b1) begin
      expect_eq("pcf", PCF, model_pc);
      expect_eq("pcplus4", PCPlus4F, model_pc + 32'd4);
      expect_eq("instr", instrF, mem_word(model_pc));
    end else begin
      expect_eq("nop_when_invalid", instrF, NOP_WORD);
    end
    if (imem.imem_req_valid === 1'b1) begin
      expect_eq("req_addr", imem.imem_addr, model_pc);
    end
    expect_eq("misalign", {31'd0, misalign_o}, {31'd0, model_fault});
    if (model_fault) begin
      expect_eq("fault_req", {31'd0, imem.imem_req_valid}, 32'd0);
      expect_eq("fault_valid", {31'd0, validF}, 32'd0);
    end
  endtask

  // Advance the reference model by the edge about to happen, then check.
  task automatic step();
    if (!rst_n) begin
      model_pc    = RESET_VAL;
      model_fault = 1'b0;
    end else if (!model_fault) begin
      if (PCSrcE) begin
`ifdef FETCH_MISALIGN_TRAP_EN
        if (PCTargetE[1:0] != 2'b00) model_fault = 1'b1;
        else model_pc = PCTargetE;
`else
        model_pc = PCTargetE & 32'hFFFF_FFFC;
`endif
      end else if (validF === 1'b1 && !StallF) begin
        model_pc = model_pc + 32'd4;
        deliveries++;
      end
    end
    @(negedge clk);
    checkOutput();
  endtask

  task automatic wait_valid(input int max_cycles, input string tag);
    int n = 0;
    while (validF !== 1'b1 && n < max_cycles) begin
      step();
      n++;
    end
    checks++;
    assert (validF === 1'b1)
    else begin
      errors++;
      $error("[TB] FAIL %s: validF observed %b expected 1 within %0d cycles", tag, validF, max_cycles);
    end
  endtask

  task automatic wait_req(input int max_cycles, input string tag);
    int n = 0;
    while (imem.imem_req_valid !== 1'b1 && n < max_cycles) begin
      step();
      n++;
    end
    checks++;
    assert (imem.imem_req_valid === 1'b1)
    else begin
      errors++;
      $error("[TB] FAIL %s: imem_req_valid observed %b expected 1 within %0d cycles", tag, imem.imem_req_valid, max_cycles);
    end
  endtask

  // Instruction memory: accepts at most one request, answers after a latency.
  initial begin
    imem.imem_req_ready = 1'b0;
    imem.imem_rsp_valid = 1'b0;
    imem.imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      #1;
      imem.imem_rsp_valid = 1'b0;
      if (!rst_n) begin
        mem_pending         = 1'b0;
        imem.imem_req_ready = 1'b0;
      end else begin
        if (mem_pending) begin
          if (mem_cnt <= 1) begin
            imem.imem_rsp_valid = 1'b1;
            imem.imem_rsp_data  = mem_word(mem_addr_q);
            mem_pending         = 1'b0;
          end else begin
            mem_cnt--;
          end
        end
        if (mem_pending) begin
          checks++;
          assert (imem.imem_req_valid === 1'b0)
          else begin
            errors++;
            $error("[TB] FAIL outstanding: imem_req_valid observed %b expected 0", imem.imem_req_valid);
          end
        end
        imem.imem_req_ready = mem_random ? ($urandom_range(0, 1) == 1) : 1'b1;
        if (imem.imem_req_valid === 1'b1 && imem.imem_req_ready) begin
          mem_pending = 1'b1;
          mem_cnt     = mem_random ? int'($urandom_range(1, 3)) : mem_lat;
          mem_addr_q  = imem.imem_addr;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int d0;
    logic [31:0] tgt;

    applyStimulus(1'b0, 1'b0, 32'h0);
    #1 rst_n = 1'b0;
    @(negedge clk);
    expect_eq("rst_validF", {31'd0, validF}, 32'd0);
    expect_eq("rst_instrF", instrF, NOP_WORD);
    expect_eq("rst_PCF", PCF, RESET_VAL);
    expect_eq("rst_PCPlus4F", PCPlus4F, RESET_VAL + 32'd4);
    expect_eq("rst_misalign", {31'd0, misalign_o}, 32'd0);
    expect_eq("rst_req_valid", {31'd0, imem.imem_req_valid}, 32'd0);
    rst_n = 1'b1;

    $display("[TB] sequential fetch");
    for (int k = 0; k < 2; k++) begin
      wait_valid(20, "seq_valid");
      expect_eq("seq_pcf", PCF, 32'(k * 4));
      step();
    end
    wait_valid(20, "seq_valid_8");
    expect_eq("seq_pcf_8", PCF, 32'h8);

    $display("[TB] stall in hold");
    applyStimulus(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      expect_eq("stall_valid", {31'd0, validF}, 32'd1);
      expect_eq("stall_pcf", PCF, 32'h8);
      expect_eq("stall_instr", instrF, mem_word(32'h8));
    end
    applyStimulus(1'b0, 1'b0, 32'h0);
    step();
    expect_eq("resume_valid", {31'd0, validF}, 32'd0);
    expect_eq("resume_req", {31'd0, imem.imem_req_valid}, 32'd1);
    expect_eq("resume_addr", imem.imem_addr, 32'hC);

    $display("[TB] redirect while waiting");
    mem_lat = 3;
    step();
    applyStimulus(1'b0, 1'b1, 32'h100);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0);
    expect_eq("kill_no_req", {31'd0, imem.imem_req_valid}, 32'd0);
    wait_req(10, "redirect_req");
    expect_eq("redirect_addr", imem.imem_addr, 32'h100);
    mem_lat = 1;
    wait_valid(20, "redirect_valid");
    expect_eq("redirect_pcf", PCF, 32'h100);
    step();

    $display("[TB] redirect with response and stall");
    wait_req(10, "pre_coincide");
    step();
    applyStimulus(1'b1, 1'b1, 32'h200);
    step();
    expect_eq("coincide_valid", {31'd0, validF}, 32'd0);
    expect_eq("coincide_req", {31'd0, imem.imem_req_valid}, 32'd1);
    expect_eq("coincide_addr", imem.imem_addr, 32'h200);

    $display("[TB] wrap-around");
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0);
    wait_valid(20, "wrap_valid");
    expect_eq("wrap_pcf", PCF, 32'hFFFF_FFFC);
    expect_eq("wrap_pcplus4", PCPlus4F, 32'h0);
    step();
    wait_req(10, "wrap_req");
    expect_eq("wrap_next_addr", imem.imem_addr, 32'h0);

    $display("[TB] misaligned redirect");
    applyStimulus(1'b0, 1'b1, 32'h102);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
    for (int i = 0; i < 4; i++) begin
      step();
      expect_eq("trap_misalign", {31'd0, misalign_o}, 32'd1);
      expect_eq("trap_no_req", {31'd0, imem.imem_req_valid}, 32'd0);
    end
    applyStimulus(1'b0, 1'b1, 32'h300);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0);
    step();
    expect_eq("trap_sticky", {31'd0, misalign_o}, 32'd1);
    expect_eq("trap_sticky_req", {31'd0, imem.imem_req_valid}, 32'd0);
`else
    wait_valid(20, "masked_valid");
    expect_eq("masked_pcf", PCF, 32'h100);
    expect_eq("masked_misalign", {31'd0, misalign_o}, 32'd0);
    step();
    mem_lat = 3;
    wait_req(10, "pre_reset_req");
    step();
`endif

    $display("[TB] reset during transaction");
    rst_n = 1'b0;
    step();
    expect_eq("rst2_validF", {31'd0, validF}, 32'd0);
    expect_eq("rst2_req_valid", {31'd0, imem.imem_req_valid}, 32'd0);
    expect_eq("rst2_PCF", PCF, RESET_VAL);
    expect_eq("rst2_PCPlus4F", PCPlus4F, RESET_VAL + 32'd4);
    expect_eq("rst2_misalign", {31'd0, misalign_o}, 32'd0);
    rst_n = 1'b1;
    mem_lat = 1;
    wait_valid(20, "post_reset_valid");
    expect_eq("post_reset_pcf", PCF, RESET_VAL);
    step();

    $display("[TB] randomized traffic");
    mem_random = 1'b1;
    d0 = deliveries;
    for (int i = 0; i < 800; i++) begin
`ifdef FETCH_MISALIGN_TRAP_EN
      tgt = $urandom & 32'h0000_3FFC;
`else
      tgt = $urandom & 32'h0000_3FFF;
`endif
      applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 11) == 0, tgt);
      step();
    end
    applyStimulus(1'b0, 1'b0, 32'h0);
    checks++;
    assert (deliveries - d0 >= 20)
    else begin
      errors++;
      $error("[TB] FAIL random_progress: delivered %0d required at least 20", deliveries - d0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
